// File: rtl/regfile_pkg.sv
// Shared register-file types: address/data widths, writeback arbiter states and write request.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;   // RegAddrBus width
  localparam int REG_DATA_W = 32;  // RegBus width

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FORCE
  } wb_state_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Synchronous FIFO with the head visible combinationally (zero-latency read).
// A push while full is taken only when a pop happens in the same cycle.
module wb_result_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_dat_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the regfile write port between pipeline writeback (priority) and buffered LLU results,
// forcing a drain via stall_req when the FIFO head starves, and tracking pending LLU writes per register.
module wb_port_arbiter
  import regfile_pkg::*;
#(
  parameter int ADDR_W     = REG_ADDR_W,
  parameter int DATA_W     = REG_DATA_W,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_we,
  input  logic [ADDR_W-1:0]     pipe_waddr,
  input  logic [DATA_W-1:0]     pipe_wdata,
  input  logic                  issue_valid,
  input  logic [ADDR_W-1:0]     issue_waddr,
  input  logic                  llu_valid,
  output logic                  llu_ready,
  input  logic [ADDR_W-1:0]     llu_waddr,
  input  logic [DATA_W-1:0]     llu_wdata,
  output logic                  rf_we,
  output logic [ADDR_W-1:0]     rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic [2**ADDR_W-1:0]  busy_mask,
  output logic                  stall_req
);

  localparam int NREG  = 2**ADDR_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int AGE_W = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  req_t             push_req, head;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop, pipe_slot, last_entry;
  logic [CNT_W-1:0] fifo_count;

  wb_state_e        state_q, state_d;
  logic [AGE_W-1:0] age_q, age_d;
  logic [NREG-1:0]  busy_q, busy_d;
  logic             stall_q;

  assign push_req  = '{addr: llu_waddr, data: llu_wdata};
  assign llu_ready = !fifo_full;
  assign pipe_slot = pipe_we && (pipe_waddr != '0);
  // Results for r0 are acknowledged but never stored.
  assign fifo_push = !rst && llu_valid && llu_ready && (llu_waddr != '0);
  assign fifo_pop  = !rst && !pipe_slot && !fifo_empty;
  assign last_entry = (fifo_count == CNT_W'(1));

  wb_result_fifo #(
    .WIDTH ($bits(req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (fifo_push),
    .push_dat_i (push_req),
    .pop_i      (fifo_pop),
    .head_o     (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (!rst) begin
      if (pipe_slot) begin
        rf_we    = 1'b1;
        rf_waddr = pipe_waddr;
        rf_wdata = pipe_wdata;
      end else if (!fifo_empty) begin
        rf_we    = 1'b1;
        rf_waddr = head.addr;
        rf_wdata = head.data;
      end
    end
  end

  always_comb begin
    age_d = age_q;
    if (fifo_pop || fifo_empty) begin
      age_d = '0;
    end else if (age_q != AGE_W'(STARVE_MAX)) begin
      age_d = age_q + AGE_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (fifo_push) state_d = DRAIN;
      end
      DRAIN: begin
        if (fifo_pop && last_entry && !fifo_push) begin
          state_d = IDLE;
        end else if (!fifo_pop && (age_q == AGE_W'(STARVE_MAX - 1))) begin
          state_d = FORCE;
        end
      end
      FORCE: begin
        if (fifo_pop) state_d = (last_entry && !fifo_push) ? IDLE : DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Clear before set so an issue in the same cycle as the old result's write keeps the bit.
  always_comb begin
    busy_d = busy_q;
    if (fifo_pop) busy_d[head.addr] = 1'b0;
    if (issue_valid && (issue_waddr != '0)) busy_d[issue_waddr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      age_q   <= '0;
      busy_q  <= '0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      age_q   <= age_d;
      busy_q  <= busy_d;
      stall_q <= (state_d == FORCE);
    end
  end

  assign busy_mask = busy_q;
  assign stall_req = stall_q;

  // Pipeline must not write a register whose LLU result is still outstanding.
  assert property (@(posedge clk) disable iff (rst) !(pipe_slot && busy_q[pipe_waddr]));

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with a queue-based reference model checked every cycle.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        issue_valid;
  logic [4:0]  issue_waddr;
  logic        llu_valid;
  logic        llu_ready;
  logic [4:0]  llu_waddr;
  logic [31:0] llu_wdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] busy_mask;
  logic        stall_req;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_port_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .pipe_we     (pipe_we),
    .pipe_waddr  (pipe_waddr),
    .pipe_wdata  (pipe_wdata),
    .issue_valid (issue_valid),
    .issue_waddr (issue_waddr),
    .llu_valid   (llu_valid),
    .llu_ready   (llu_ready),
    .llu_waddr   (llu_waddr),
    .llu_wdata   (llu_wdata),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .busy_mask   (busy_mask),
    .stall_req   (stall_req)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of buffered results, per-register pending bits, head wait count.
  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mbusy  = '0;
  int          mwait  = 0;
  bit          mstall = 1'b0;

  always @(negedge clk) begin
    bit          pslot, pop, acc;
    logic        e_we;
    logic [4:0]  e_a;
    logic [31:0] e_d;
    if (rst) begin
      chk("rst_rf_we", 64'(rf_we), 64'(0));
      mq.delete();
      mbusy  = '0;
      mwait  = 0;
      mstall = 1'b0;
    end else begin
      pslot = pipe_we && (pipe_waddr != 5'd0);
      e_we = 1'b0; e_a = '0; e_d = '0;
      if (pslot) begin
        e_we = 1'b1; e_a = pipe_waddr; e_d = pipe_wdata;
      end else if (mq.size() > 0) begin
        e_we = 1'b1; e_a = mq[0].a; e_d = mq[0].d;
      end
      chk("m_rf_we", 64'(rf_we), 64'(e_we));
      chk("m_rf_waddr", 64'(rf_waddr), 64'(e_a));
      chk("m_rf_wdata", 64'(rf_wdata), 64'(e_d));
      chk("m_llu_ready", 64'(llu_ready), 64'(mq.size() < 2));
      chk("m_busy_mask", 64'(busy_mask), 64'(mbusy));
      chk("m_stall_req", 64'(stall_req), 64'(mstall));
      pop = !pslot && (mq.size() > 0);
      acc = llu_valid && (mq.size() < 2) && (llu_waddr != 5'd0);
      if (pop) begin
        mbusy[mq[0].a] = 1'b0;
        void'(mq.pop_front());
        mwait  = 0;
        mstall = 1'b0;
      end else if (mq.size() > 0) begin
        mwait++;
        if (mwait >= 4) mstall = 1'b1;
      end else begin
        mwait = 0;
      end
      if (acc) mq.push_back('{a: llu_waddr, d: llu_wdata});
      if (issue_valid && issue_waddr != 5'd0) mbusy[issue_waddr] = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; pipe_we = 1'b0; pipe_waddr = '0; pipe_wdata = '0;
    issue_valid = 1'b0; issue_waddr = '0; llu_valid = 1'b0; llu_waddr = '0; llu_wdata = '0;
    repeat (3) step();
    #2;
    chk("rst_busy", 64'(busy_mask), 64'(0));
    chk("rst_stall", 64'(stall_req), 64'(0));
    chk("rst_rf_waddr", 64'(rf_waddr), 64'(0));
    step(); rst = 1'b0;

    // 1: idle
    repeat (10) begin
      step(); #2;
      chk("idle_rf_we", 64'(rf_we), 64'(0));
      chk("idle_busy", 64'(busy_mask), 64'(0));
      chk("idle_ready", 64'(llu_ready), 64'(1));
    end

    // 2: issue r5, then its result
    step(); issue_valid = 1'b1; issue_waddr = 5'd5;
    step(); issue_valid = 1'b0;
    llu_valid = 1'b1; llu_waddr = 5'd5; llu_wdata = 32'hDEADBEEF;
    #2; chk("t2_busy5_set", 64'(busy_mask[5]), 64'(1));
    chk("t2_push_no_we", 64'(rf_we), 64'(0));
    step(); llu_valid = 1'b0; #2;
    chk("t2_we", 64'(rf_we), 64'(1));
    chk("t2_waddr", 64'(rf_waddr), 64'(5));
    chk("t2_wdata", 64'(rf_wdata), 64'hDEADBEEF);
    chk("t2_busy5_hold", 64'(busy_mask[5]), 64'(1));
    step(); #2;
    chk("t2_busy5_clr", 64'(busy_mask[5]), 64'(0));

    // 3: collision
    step(); llu_valid = 1'b1; llu_waddr = 5'd7; llu_wdata = 32'h22;
    step(); llu_valid = 1'b0; pipe_we = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'h11; #2;
    chk("t3_pipe_addr", 64'(rf_waddr), 64'(3));
    chk("t3_pipe_data", 64'(rf_wdata), 64'h11);
    step(); pipe_we = 1'b0; #2;
    chk("t3_llu_addr", 64'(rf_waddr), 64'(7));
    chk("t3_llu_data", 64'(rf_wdata), 64'h22);
    step(); #2;
    chk("t3_done_we", 64'(rf_we), 64'(0));

    // 4: starvation
    step(); llu_valid = 1'b1; llu_waddr = 5'd7; llu_wdata = 32'h77;
    pipe_we = 1'b1; pipe_waddr = 5'd10; pipe_wdata = 32'h1;
    step(); llu_valid = 1'b0; #2;
    chk("t4_no_stall_yet", 64'(stall_req), 64'(0));
    n = 0;
    while (!stall_req && n < 20) begin
      step(); #2; n++;
    end
    chk("t4_starve_cycles", 64'(n), 64'(4));
    step(); pipe_we = 1'b0; #2;
    chk("t4_force_addr", 64'(rf_waddr), 64'(7));
    chk("t4_force_data", 64'(rf_wdata), 64'h77);
    chk("t4_stall_during", 64'(stall_req), 64'(1));
    step(); #2;
    chk("t4_stall_drop", 64'(stall_req), 64'(0));

    // 5: full FIFO, third result held until a slot frees
    step(); pipe_we = 1'b1; pipe_waddr = 5'd11; pipe_wdata = 32'h2;
    llu_valid = 1'b1; llu_waddr = 5'd1; llu_wdata = 32'hA1;
    step(); llu_waddr = 5'd2; llu_wdata = 32'hA2;
    step(); llu_waddr = 5'd6; llu_wdata = 32'hA6; #2;
    chk("t5_full_ready", 64'(llu_ready), 64'(0));
    step(); #2;
    chk("t5_still_full", 64'(llu_ready), 64'(0));
    step(); pipe_we = 1'b0; #2;
    chk("t5_w1_addr", 64'(rf_waddr), 64'(1));
    chk("t5_w1_ready", 64'(llu_ready), 64'(0));
    n = 0;
    while (!llu_ready && n < 10) begin
      step(); #2; n++;
    end
    chk("t5_ready_back", 64'(llu_ready), 64'(1));
    chk("t5_w2_addr", 64'(rf_waddr), 64'(2));
    step(); llu_valid = 1'b0; #2;
    chk("t5_w3_addr", 64'(rf_waddr), 64'(6));
    chk("t5_w3_data", 64'(rf_wdata), 64'hA6);
    step(); #2;
    chk("t5_empty_we", 64'(rf_we), 64'(0));

    // 6: reset with two buffered results
    step(); issue_valid = 1'b1; issue_waddr = 5'd4;
    step(); issue_waddr = 5'd9; pipe_we = 1'b1; pipe_waddr = 5'd12; pipe_wdata = 32'h3;
    llu_valid = 1'b1; llu_waddr = 5'd4; llu_wdata = 32'h44;
    step(); issue_valid = 1'b0; llu_waddr = 5'd9; llu_wdata = 32'h99;
    step(); llu_valid = 1'b0; #2;
    chk("t6_busy4", 64'(busy_mask[4]), 64'(1));
    chk("t6_busy9", 64'(busy_mask[9]), 64'(1));
    chk("t6_full", 64'(llu_ready), 64'(0));
    step(); rst = 1'b1; pipe_we = 1'b0; #2;
    chk("t6_rst_we", 64'(rf_we), 64'(0));
    step(); rst = 1'b0; #2;
    chk("t6_busy_clr", 64'(busy_mask), 64'(0));
    chk("t6_ready", 64'(llu_ready), 64'(1));
    repeat (3) begin
      step(); #2;
      chk("t6_no_replay", 64'(rf_we), 64'(0));
    end

    // r0 never marks busy nor writes
    step(); issue_valid = 1'b1; issue_waddr = 5'd0;
    pipe_we = 1'b1; pipe_waddr = 5'd0; pipe_wdata = 32'h5;
    llu_valid = 1'b1; llu_waddr = 5'd0; llu_wdata = 32'h55; #2;
    chk("r0_pipe_we", 64'(rf_we), 64'(0));
    step(); issue_valid = 1'b0; pipe_we = 1'b0; llu_valid = 1'b0; #2;
    chk("r0_busy", 64'(busy_mask), 64'(0));
    chk("r0_discard_we", 64'(rf_we), 64'(0));
    chk("r0_ready", 64'(llu_ready), 64'(1));

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
